// File: rtl/sys_pkg.sv
// Shared definitions for the UART TX byte buffer: FSM state encoding and default byte width.
package sys_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_ctrl_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; all flags derive from the registered pointers.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic                  do_push, do_pop;

    // Same slot address with opposite wrap bits means the writer is a full lap ahead.
    assign full_o  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                     (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q + (ADDR_WIDTH+1)'(do_push);
        rptr_d = rptr_q + (ADDR_WIDTH+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rptr_q[ADDR_WIDTH-1:0]];

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffers bytes for the UART TX path and releases them one per busy handshake as TX_VLD pulses,
// with sticky overflow and handshake-timeout flags.
module uart_tx_fifo_ctrl
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VLD,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVF,
    output logic                  TO_ERR
);

    localparam int            TW      = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    tx_state_e             state_q, state_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  ovf_q, ovf_d;
    logic                  to_err_q, to_err_d;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic                  cnt_clr, cnt_inc, to_set, to_hit;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push = WR_EN & ~fifo_full;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RST),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (WR_DATA),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (COUNT)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign to_hit = (tcnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && !TX_BUSY) state_d = SEND;
            SEND:    state_d = WAIT_HI;
            WAIT_HI: begin
                if (TX_BUSY)     state_d = WAIT_LO;
                else if (to_hit) state_d = IDLE;
            end
            WAIT_LO: if (!TX_BUSY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        TX_VLD  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        to_set  = 1'b0;
        case (state_q)
            IDLE:    pop = !fifo_empty && !TX_BUSY;
            SEND: begin
                TX_VLD  = 1'b1;
                cnt_clr = 1'b1;
            end
            WAIT_HI: begin
                cnt_inc = !TX_BUSY && !to_hit;
                to_set  = !TX_BUSY && to_hit;
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_data_d = pop ? fifo_rd_data : tx_data_q;
        tcnt_d    = cnt_clr ? '0 : (cnt_inc ? tcnt_q + 1'b1 : tcnt_q);
        ovf_d     = ovf_q | (WR_EN & fifo_full);
        to_err_d  = to_err_q | to_set;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_data_q <= '0;
            tcnt_q    <= '0;
            ovf_q     <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            tcnt_q    <= tcnt_d;
            ovf_q     <= ovf_d;
            to_err_q  <= to_err_d;
        end
    end

    assign TX_DATA = tx_data_q;
    assign FULL    = fifo_full;
    assign EMPTY   = fifo_empty;
    assign OVF     = ovf_q;
    assign TO_ERR  = to_err_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: single byte, burst, overflow, timeout, wrap stream, reset.
module tb_uart_tx_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] WR_DATA;
    logic       WR_EN;
    logic       TX_BUSY;
    logic [7:0] TX_DATA;
    logic       TX_VLD;
    logic       FULL;
    logic       EMPTY;
    logic [3:0] COUNT;
    logic       OVF;
    logic       TO_ERR;

    logic       busy_man  = 1'b0;
    logic       busy_auto = 1'b0;
    logic       auto_en   = 1'b0;
    int         a_cnt     = 0;
    int         a_hold    = 2;
    int         fall_events = 0;

    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    logic       vld_prev = 1'b0;
    int         bb_events = 0;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign TX_BUSY = auto_en ? busy_auto : busy_man;

    uart_tx_fifo_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR_DATA (WR_DATA),
        .WR_EN   (WR_EN),
        .TX_BUSY (TX_BUSY),
        .TX_DATA (TX_DATA),
        .TX_VLD  (TX_VLD),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .COUNT   (COUNT),
        .OVF     (OVF),
        .TO_ERR  (TO_ERR)
    );

    // Record every pulse and flag any two in consecutive cycles.
    always @(negedge CLK) begin
        if (!RST && TX_VLD) begin
            sent_q.push_back(TX_DATA);
            if (vld_prev) bb_events++;
        end
        vld_prev = TX_VLD;
    end

    // Busy responder: rises two cycles after a pulse, holds 2..4 cycles, then falls.
    always @(negedge CLK) begin
        if (!auto_en) begin
            a_cnt     = 0;
            busy_auto = 1'b0;
        end else if (TX_VLD) begin
            a_cnt = 1;
        end else if (a_cnt > 0) begin
            a_cnt++;
            if (a_cnt == 3) busy_auto = 1'b1;
            if (a_cnt == 3 + a_hold) begin
                busy_auto = 1'b0;
                a_cnt     = 0;
                fall_events++;
                a_hold    = (a_hold % 3) + 2;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Release busy, wait for the next pulse, then run one full busy high-low handshake.
    task automatic serve(input logic [7:0] exp, input string tag);
        int n = 0;
        busy_man = 1'b0;
        while (!TX_VLD && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_vld"}, 32'(TX_VLD), 32'd1);
        check_val({tag, "_data"}, 32'(TX_DATA), 32'(exp));
        tick();
        busy_man = 1'b1;
        tick(3);
        check_val({tag, "_hold"}, 32'(TX_DATA), 32'(exp));
        busy_man = 1'b0;
    endtask

    initial begin
        int sent_before;
        RST     = 1'b1;
        WR_DATA = 8'h00;
        WR_EN   = 1'b0;
        tick(2);
        check_val("rst_count", 32'(COUNT), 32'd0);
        check_val("rst_empty", 32'(EMPTY), 32'd1);
        check_val("rst_full", 32'(FULL), 32'd0);
        check_val("rst_vld", 32'(TX_VLD), 32'd0);
        check_val("rst_data", 32'(TX_DATA), 32'd0);
        RST = 1'b0;
        tick();

        // Single byte: EMPTY drops one cycle after the write, pulse one cycle later.
        WR_DATA = 8'hA5;
        WR_EN   = 1'b1;
        tick();
        WR_EN   = 1'b0;
        check_val("t1_empty", 32'(EMPTY), 32'd0);
        check_val("t1_early_vld", 32'(TX_VLD), 32'd0);
        tick();
        check_val("t1_vld", 32'(TX_VLD), 32'd1);
        check_val("t1_data", 32'(TX_DATA), 32'hA5);
        exp_q.push_back(8'hA5);
        tick(5);
        busy_man = 1'b1;
        tick(40);
        busy_man = 1'b0;
        tick(3);
        check_val("t1_empty_end", 32'(EMPTY), 32'd1);
        check_val("t1_data_stable", 32'(TX_DATA), 32'hA5);
        check_val("t1_npulse", 32'(sent_q.size()), 32'd1);

        // Burst of three held behind busy, then drained one handshake at a time.
        busy_man = 1'b1;
        tick();
        WR_EN = 1'b1;
        WR_DATA = 8'h12; tick();
        WR_DATA = 8'h34; tick();
        WR_DATA = 8'h56; tick();
        WR_EN = 1'b0;
        check_val("t2_count", 32'(COUNT), 32'd3);
        check_val("t2_no_pop", 32'(sent_q.size()), 32'd1);
        serve(8'h12, "t2_b0");
        serve(8'h34, "t2_b1");
        serve(8'h56, "t2_b2");
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        tick(2);
        check_val("t2_empty", 32'(EMPTY), 32'd1);

        // Overflow: ninth byte into a full FIFO is dropped.
        busy_man = 1'b1;
        tick();
        WR_EN = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            WR_DATA = 8'(i);
            tick();
        end
        check_val("t3_full", 32'(FULL), 32'd1);
        check_val("t3_count8", 32'(COUNT), 32'd8);
        check_val("t3_ovf_pre", 32'(OVF), 32'd0);
        WR_DATA = 8'h09;
        tick();
        WR_EN = 1'b0;
        check_val("t3_ovf", 32'(OVF), 32'd1);
        check_val("t3_count", 32'(COUNT), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            serve(8'(i), "t3_b");
            exp_q.push_back(8'(i));
        end
        tick(20);
        check_val("t3_empty", 32'(EMPTY), 32'd1);
        check_val("t3_ovf_sticky", 32'(OVF), 32'd1);

        // Timeout: busy never rises after the pulse.
        WR_DATA = 8'h7E;
        WR_EN   = 1'b1;
        tick();
        WR_EN   = 1'b0;
        tick();
        check_val("t4_vld", 32'(TX_VLD), 32'd1);
        check_val("t4_data", 32'(TX_DATA), 32'h7E);
        exp_q.push_back(8'h7E);
        tick(64);
        check_val("t4_to_early", 32'(TO_ERR), 32'd0);
        tick();
        check_val("t4_to", 32'(TO_ERR), 32'd1);
        WR_DATA = 8'h7F;
        WR_EN   = 1'b1;
        tick();
        WR_EN   = 1'b0;
        serve(8'h7F, "t4_next");
        exp_q.push_back(8'h7F);
        tick(2);
        check_val("t4_to_sticky", 32'(TO_ERR), 32'd1);

        // Wrap-around stream with the busy responder and pushes aligned to pops.
        begin
            int  nxt = 0, cyc = 0, exp_cnt = 0, simul = 0;
            int  fall_start, seen_fall;
            bit  wr, acc;
            fall_start = fall_events;
            seen_fall  = fall_events;
            auto_en    = 1'b1;
            while ((fall_events - fall_start) < 20 && cyc < 3000) begin
                wr = (nxt < 20) && ((fall_events != seen_fall) || exp_cnt < 3);
                seen_fall = fall_events;
                WR_DATA = nxt[7:0];
                WR_EN   = wr;
                acc     = wr && (exp_cnt < 8);
                tick();
                cyc++;
                if (wr) nxt++;
                if (acc && TX_VLD) simul++;
                exp_cnt = exp_cnt + int'(acc) - int'(TX_VLD);
                check_val("t5_count", 32'(COUNT), 32'(exp_cnt));
            end
            WR_EN = 1'b0;
            check_val("t5_done", 32'(fall_events - fall_start), 32'd20);
            check_val("t5_simul", 32'(simul > 0), 32'd1);
            auto_en = 1'b0;
            for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
            tick(3);
            check_val("t5_empty", 32'(EMPTY), 32'd1);
        end

        // Reset while in WAIT_LO with four bytes still queued.
        busy_man = 1'b1;
        tick();
        WR_EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            WR_DATA = 8'hC0 + 8'(i);
            tick();
        end
        WR_EN = 1'b0;
        check_val("t6_count5", 32'(COUNT), 32'd5);
        busy_man = 1'b0;
        tick();
        check_val("t6_vld", 32'(TX_VLD), 32'd1);
        check_val("t6_data", 32'(TX_DATA), 32'hC0);
        exp_q.push_back(8'hC0);
        busy_man = 1'b1;
        tick(3);
        check_val("t6_count4", 32'(COUNT), 32'd4);
        sent_before = sent_q.size();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_val("t6_rst_count", 32'(COUNT), 32'd0);
        check_val("t6_rst_empty", 32'(EMPTY), 32'd1);
        check_val("t6_rst_full", 32'(FULL), 32'd0);
        check_val("t6_rst_data", 32'(TX_DATA), 32'd0);
        check_val("t6_rst_vld", 32'(TX_VLD), 32'd0);
        check_val("t6_rst_ovf", 32'(OVF), 32'd0);
        check_val("t6_rst_to", 32'(TO_ERR), 32'd0);
        busy_man = 1'b0;
        tick(30);
        check_val("t6_no_send", 32'(sent_q.size()), 32'(sent_before));

        check_val("n_sent", 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            check_val($sformatf("order_%0d", i), 32'(sent_q[i]), 32'(exp_q[i]));
        check_val("no_b2b", 32'(bb_events), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
